// File: rtl/core_lsu_wport.sv
// Dcache write port: hit writes, line refill with dirty writeback, uncached
// single-beat accesses and invalidate ops, mastering an AXI-like burst bus.
module core_lsu_wport #(
    parameter  int WAY_CNT  = 2,
    localparam int WAY_BITS = $clog2(WAY_CNT),
    localparam int TAG_W    = 22,
    localparam int RSTATE_W = 77 + WAY_CNT * (1 + 32 + TAG_W),
    localparam int WSTATE_W = 46,
    localparam int WREQ_W   = 72 + WAY_CNT * 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RSTATE_W-1:0] rstate_i,
    output logic [WSTATE_W-1:0] wstate_o,
    output logic [WREQ_W-1:0]   wreq_o,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    output logic [31:0]         ar_addr_o,
    output logic [7:0]          ar_len_o,
    output logic [1:0]          ar_size_o,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic [31:0]         aw_addr_o,
    output logic [7:0]          aw_len_o,
    output logic [1:0]          aw_size_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    output logic [31:0]         w_data_o,
    output logic [3:0]          w_strb_o,
    output logic                w_last_o,
    input  logic                b_valid_i,
    input  logic                r_valid_i,
    input  logic [31:0]         r_data_i,
    input  logic                r_last_i
);

    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [19:0] tag;
    } dcache_tag_t;

    typedef struct packed {
        logic                     cache_refill_valid;
        logic                     miss_write_req_valid;
        logic                     uncached_read;
        logic                     uncached_write_valid;
        logic                     hit_write_req_valid;
        logic                     cache_op_inv;
        logic                     cache_op_invwb;
        logic [31:0]              addr;
        logic [1:0]               rwsize;
        logic [WAY_CNT-1:0]       wsel;
        logic [3:0]               wstrobe;
        logic [31:0]              wdata;
        logic [WAY_CNT-1:0][31:0] rdata;
        dcache_tag_t [WAY_CNT-1:0] tag_rdata;
    } rport_state_t;

    typedef struct packed {
        logic        dram_take_over;
        logic [9:0]  data_raddr;
        logic        read_ready;
        logic [31:0] rdata;
        logic        uop_ready;
        logic        uncached_write_ready;
    } wport_state_t;

    typedef struct packed {
        logic [9:0]              data_waddr;
        logic [WAY_CNT-1:0][3:0] data_we;
        logic [31:0]             data_wdata;
        logic [7:0]              tag_waddr;
        logic [WAY_CNT-1:0]      tag_we;
        dcache_tag_t             tag_wdata;
    } wport_wreq_t;

    typedef enum logic [3:0] {
        IDLE, WB_RD, WB_AW, WB_W, WB_B, RF_AR, RF_R, RF_TAG,
        UC_AR, UC_R, UC_AW, UC_W, UC_B, INV
    } state_e;

    typedef enum logic [2:0] {
        OP_RF_RD, OP_RF_WR, OP_UC_RD, OP_UC_WR, OP_INV, OP_INVWB
    } op_e;

    rport_state_t rs;
    wport_state_t ws;
    wport_wreq_t  wr;

    assign rs       = rstate_i;
    assign wstate_o = ws;
    assign wreq_o   = wr;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [WAY_BITS-1:0] way_q, way_d;
    logic [WAY_BITS-1:0] rr_q, rr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [1:0]          rwsize_q, rwsize_d;
    logic [3:0]          wstrobe_q, wstrobe_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [19:0]         vtag_q, vtag_d;
    logic [3:0][31:0]    line_q, line_d;
    logic [31:0]         word_q, word_d;

    logic [WAY_BITS-1:0] victim;
    logic [WAY_BITS-1:0] inv_way;
    dcache_tag_t         victim_tag;
    dcache_tag_t         inv_tag;
    logic                req_inv;
    logic                req_refill;
    logic [31:0]         merged;

    assign req_inv    = rs.cache_op_inv | rs.cache_op_invwb;
    assign req_refill = rs.cache_refill_valid | rs.miss_write_req_valid;
    assign inv_way    = rs.addr[WAY_BITS-1:0];
    assign inv_tag    = rs.tag_rdata[inv_way];
    assign victim_tag = rs.tag_rdata[victim];

    // Lowest-index invalid way wins; descending loop leaves the lowest one last.
    always_comb begin
        victim = rr_q;
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (!rs.tag_rdata[w].valid) victim = WAY_BITS'(w);
        end
    end

    always_comb begin
        merged = r_data_i;
        for (int b = 0; b < 4; b++) begin
            if (wstrobe_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        way_d     = way_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rwsize_d  = rwsize_q;
        wstrobe_d = wstrobe_q;
        wdata_d   = wdata_q;
        vtag_d    = vtag_q;
        line_d    = line_q;
        word_d    = word_q;
        unique case (state_q)
            IDLE: begin
                if (req_inv || req_refill || rs.uncached_read || rs.uncached_write_valid) begin
                    addr_d    = rs.addr;
                    rwsize_d  = rs.rwsize;
                    wstrobe_d = rs.wstrobe;
                    wdata_d   = rs.wdata;
                    cnt_d     = '0;
                    if (req_inv) begin
                        op_d    = rs.cache_op_invwb ? OP_INVWB : OP_INV;
                        way_d   = inv_way;
                        vtag_d  = inv_tag.tag;
                        state_d = (rs.cache_op_invwb && inv_tag.valid && inv_tag.dirty) ? WB_RD : INV;
                    end else if (req_refill) begin
                        op_d    = rs.miss_write_req_valid ? OP_RF_WR : OP_RF_RD;
                        way_d   = victim;
                        vtag_d  = victim_tag.tag;
                        rr_d    = rr_q + WAY_BITS'(1);
                        state_d = (victim_tag.valid && victim_tag.dirty) ? WB_RD : RF_AR;
                    end else if (rs.uncached_read) begin
                        op_d    = OP_UC_RD;
                        state_d = UC_AR;
                    end else begin
                        op_d    = OP_UC_WR;
                        state_d = UC_AW;
                    end
                end
            end
            WB_RD: begin
                // Array read data lags the address by one cycle.
                if (cnt_q != 3'd0) line_d[cnt_q[1:0] - 2'd1] = rs.rdata[way_q];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    cnt_d   = '0;
                    state_d = WB_AW;
                end
            end
            WB_AW: if (aw_ready_i) state_d = WB_W;
            WB_W: begin
                if (w_ready_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_d   = '0;
                        state_d = WB_B;
                    end
                end
            end
            WB_B:   if (b_valid_i) state_d = (op_q == OP_INVWB) ? INV : RF_AR;
            RF_AR: begin
                if (ar_ready_i) begin
                    cnt_d   = '0;
                    state_d = RF_R;
                end
            end
            RF_R: begin
                if (r_valid_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q[1:0] == addr_q[3:2]) word_d = r_data_i;
                    if (r_last_i) state_d = RF_TAG;
                end
            end
            RF_TAG: state_d = IDLE;
            INV:    state_d = IDLE;
            UC_AR:  if (ar_ready_i) state_d = UC_R;
            UC_R:   if (r_valid_i) state_d = IDLE;
            UC_AW:  if (aw_ready_i) state_d = UC_W;
            UC_W:   if (w_ready_i) state_d = UC_B;
            UC_B:   if (b_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ws         = '0;
        wr         = '0;
        ar_valid_o = 1'b0;
        ar_addr_o  = '0;
        ar_len_o   = '0;
        ar_size_o  = '0;
        aw_valid_o = 1'b0;
        aw_addr_o  = '0;
        aw_len_o   = '0;
        aw_size_o  = '0;
        w_valid_o  = 1'b0;
        w_data_o   = '0;
        w_strb_o   = '0;
        w_last_o   = 1'b0;

        if (rs.hit_write_req_valid && (state_q inside {IDLE, UC_AR, UC_R, UC_AW, UC_W, UC_B})) begin
            for (int w = 0; w < WAY_CNT; w++) begin
                wr.data_we[w] = rs.wsel[w] ? rs.wstrobe : 4'h0;
            end
            wr.data_waddr = rs.addr[11:2];
            wr.data_wdata = rs.wdata;
            wr.tag_we     = rs.wsel;
            wr.tag_waddr  = rs.addr[11:4];
            wr.tag_wdata  = '{valid: 1'b1, dirty: 1'b1, tag: rs.addr[31:12]};
        end

        unique case (state_q)
            IDLE: ws.uncached_write_ready = !req_inv && !req_refill && !rs.uncached_read;
            WB_RD: begin
                if (!cnt_q[2]) begin
                    ws.dram_take_over = 1'b1;
                    ws.data_raddr     = {addr_q[11:4], cnt_q[1:0]};
                end
            end
            WB_AW: begin
                aw_valid_o = 1'b1;
                aw_addr_o  = {vtag_q, addr_q[11:4], 4'b0};
                aw_len_o   = 8'd3;
                aw_size_o  = 2'd2;
            end
            WB_W: begin
                w_valid_o = 1'b1;
                w_data_o  = line_q[cnt_q[1:0]];
                w_strb_o  = 4'hF;
                w_last_o  = (cnt_q[1:0] == 2'd3);
            end
            RF_AR: begin
                ar_valid_o = 1'b1;
                ar_addr_o  = {addr_q[31:4], 4'b0};
                ar_len_o   = 8'd3;
                ar_size_o  = 2'd2;
            end
            RF_R: begin
                if (r_valid_i) begin
                    wr.data_we[way_q] = 4'hF;
                    wr.data_waddr     = {addr_q[11:4], cnt_q[1:0]};
                    wr.data_wdata     = (op_q == OP_RF_WR && cnt_q[1:0] == addr_q[3:2]) ? merged : r_data_i;
                end
            end
            RF_TAG: begin
                wr.tag_we[way_q] = 1'b1;
                wr.tag_waddr     = addr_q[11:4];
                wr.tag_wdata     = '{valid: 1'b1, dirty: (op_q == OP_RF_WR), tag: addr_q[31:12]};
                ws.uop_ready     = 1'b1;
                if (op_q == OP_RF_RD) begin
                    ws.read_ready = 1'b1;
                    ws.rdata      = word_q;
                end
            end
            INV: begin
                wr.tag_we[way_q] = 1'b1;
                wr.tag_waddr     = addr_q[11:4];
                ws.uop_ready     = 1'b1;
            end
            UC_AR: begin
                ar_valid_o = 1'b1;
                ar_addr_o  = addr_q;
                ar_size_o  = rwsize_q;
            end
            UC_R: begin
                if (r_valid_i) begin
                    ws.read_ready = 1'b1;
                    ws.rdata      = r_data_i;
                end
            end
            UC_AW: begin
                aw_valid_o = 1'b1;
                aw_addr_o  = addr_q;
                aw_size_o  = rwsize_q;
            end
            UC_W: begin
                w_valid_o = 1'b1;
                w_data_o  = wdata_q;
                w_strb_o  = wstrobe_q;
                w_last_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_RF_RD;
            way_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            way_q   <= way_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: payload and line-buffer registers are never read before being loaded, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        rwsize_q  <= rwsize_d;
        wstrobe_q <= wstrobe_d;
        wdata_q   <= wdata_d;
        vtag_q    <= vtag_d;
        line_q    <= line_d;
        word_q    <= word_d;
    end

endmodule

// File: tb/tb_core_lsu_wport.sv
// Directed bench for core_lsu_wport (WAY_CNT=2): inputs change just after the
// falling edge, outputs are checked 1ns later, the DUT samples on the rising edge.
module tb_core_lsu_wport;

    localparam int W = 2;

    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [19:0] tag;
    } dcache_tag_t;

    typedef struct packed {
        logic               cache_refill_valid;
        logic               miss_write_req_valid;
        logic               uncached_read;
        logic               uncached_write_valid;
        logic               hit_write_req_valid;
        logic               cache_op_inv;
        logic               cache_op_invwb;
        logic [31:0]        addr;
        logic [1:0]         rwsize;
        logic [W-1:0]       wsel;
        logic [3:0]         wstrobe;
        logic [31:0]        wdata;
        logic [W-1:0][31:0] rdata;
        dcache_tag_t [W-1:0] tag_rdata;
    } rport_state_t;

    typedef struct packed {
        logic        dram_take_over;
        logic [9:0]  data_raddr;
        logic        read_ready;
        logic [31:0] rdata;
        logic        uop_ready;
        logic        uncached_write_ready;
    } wport_state_t;

    typedef struct packed {
        logic [9:0]        data_waddr;
        logic [W-1:0][3:0] data_we;
        logic [31:0]       data_wdata;
        logic [7:0]        tag_waddr;
        logic [W-1:0]      tag_we;
        dcache_tag_t       tag_wdata;
    } wport_wreq_t;

    logic         clk;
    logic         rst_n;
    rport_state_t rs;
    wport_state_t ws;
    wport_wreq_t  wr;
    logic         ar_valid, ar_ready, aw_valid, aw_ready;
    logic [31:0]  ar_addr, aw_addr;
    logic [7:0]   ar_len, aw_len;
    logic [1:0]   ar_size, aw_size;
    logic         w_valid, w_ready, w_last, b_valid, r_valid, r_last;
    logic [31:0]  w_data, r_data;
    logic [3:0]   w_strb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0][31:0] line;

    core_lsu_wport #(.WAY_CNT(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rstate_i   (rs),
        .wstate_o   (ws),
        .wreq_o     (wr),
        .ar_valid_o (ar_valid),
        .ar_ready_i (ar_ready),
        .ar_addr_o  (ar_addr),
        .ar_len_o   (ar_len),
        .ar_size_o  (ar_size),
        .aw_valid_o (aw_valid),
        .aw_ready_i (aw_ready),
        .aw_addr_o  (aw_addr),
        .aw_len_o   (aw_len),
        .aw_size_o  (aw_size),
        .w_valid_o  (w_valid),
        .w_ready_i  (w_ready),
        .w_data_o   (w_data),
        .w_strb_o   (w_strb),
        .w_last_o   (w_last),
        .b_valid_i  (b_valid),
        .r_valid_i  (r_valid),
        .r_data_i   (r_data),
        .r_last_i   (r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rs = '0; rst_n = 1'b0;
        ar_ready = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        r_valid = 0; r_data = '0; r_last = 0;
        for (int k = 0; k < 4; k++) line[k] = 32'hDEAD_0000 + k;

        // ---- reset state
        tick(); tick(); #1;
        check("rst_uwr_ready", ws.uncached_write_ready, 1'b1);
        check("rst_ar_valid", ar_valid, 1'b0);
        check("rst_aw_valid", aw_valid, 1'b0);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_uop_ready", ws.uop_ready, 1'b0);
        check("rst_tag_we", wr.tag_we, 2'b00);
        tick(); rst_n = 1'b1;

        // ---- hit write, same cycle
        tick();
        rs.hit_write_req_valid = 1; rs.wsel = 2'b10; rs.addr = 32'h1000_0124;
        rs.wstrobe = 4'b0011; rs.wdata = 32'hAABB_CCDD;
        #1;
        check("hit_data_we", wr.data_we, 8'h30);
        check("hit_waddr", wr.data_waddr, 10'h049);
        check("hit_wdata", wr.data_wdata, 32'hAABB_CCDD);
        check("hit_tag_we", wr.tag_we, 2'b10);
        check("hit_tag_waddr", wr.tag_waddr, 8'h12);
        check("hit_tag_wdata", wr.tag_wdata, 22'h31_0000);
        check("hit_no_ar", ar_valid, 1'b0);
        check("hit_no_aw", aw_valid, 1'b0);
        tick(); rs = '0;

        // ---- refill read, both ways invalid -> way0
        tick(); rs.cache_refill_valid = 1; rs.addr = 32'h0000_2008; #1;
        check("rf_uwr_blocked", ws.uncached_write_ready, 1'b0);
        tick(); rs.cache_refill_valid = 0; #1;
        check("rf_ar_valid", ar_valid, 1'b1);
        check("rf_ar_addr", ar_addr, 32'h0000_2000);
        check("rf_ar_len", ar_len, 8'd3);
        check("rf_ar_size", ar_size, 2'd2);
        tick(); ar_ready = 1; #1;
        check("rf_ar_hold", ar_valid, 1'b1);
        tick(); ar_ready = 0; r_valid = 1; r_data = 32'h11; #1;
        check("rf_ar_drop", ar_valid, 1'b0);
        check("rf_b0_we", wr.data_we, 8'h0F);
        check("rf_b0_waddr", wr.data_waddr, 10'h000);
        check("rf_b0_wdata", wr.data_wdata, 32'h11);
        tick(); r_valid = 0; #1;
        check("rf_gap_we", wr.data_we, 8'h00);
        tick(); r_valid = 1; r_data = 32'h22; #1;
        check("rf_b1_waddr", wr.data_waddr, 10'h001);
        tick(); r_data = 32'h33; #1;
        check("rf_b2_waddr", wr.data_waddr, 10'h002);
        check("rf_b2_wdata", wr.data_wdata, 32'h33);
        tick(); r_data = 32'h44; r_last = 1; #1;
        check("rf_b3_waddr", wr.data_waddr, 10'h003);
        check("rf_b3_we", wr.data_we, 8'h0F);
        tick(); r_valid = 0; r_last = 0; #1;
        check("rf_tag_read_ready", ws.read_ready, 1'b1);
        check("rf_tag_uop_ready", ws.uop_ready, 1'b1);
        check("rf_tag_rdata", ws.rdata, 32'h33);
        check("rf_tag_we", wr.tag_we, 2'b01);
        check("rf_tag_waddr", wr.tag_waddr, 8'h00);
        check("rf_tag_wdata", wr.tag_wdata, 22'h20_0002);
        tick(); #1;
        check("rf_rr_pulse", ws.read_ready, 1'b0);
        check("rf_uop_pulse", ws.uop_ready, 1'b0);

        // ---- miss write, both ways valid+dirty, counter=1 -> writeback of way1
        tick();
        rs.tag_rdata[0] = '{valid: 1'b1, dirty: 1'b1, tag: 20'h11111};
        rs.tag_rdata[1] = '{valid: 1'b1, dirty: 1'b1, tag: 20'h0ABCD};
        rs.miss_write_req_valid = 1; rs.addr = 32'h0005_5124;
        rs.wstrobe = 4'b0101; rs.wdata = 32'hAABB_CCDD;
        #1;
        check("wb_uwr_blocked", ws.uncached_write_ready, 1'b0);
        tick(); rs.miss_write_req_valid = 0;
        rs.rdata[1] = 32'hBAD0_0001; rs.rdata[0] = 32'h0BAD_0000; #1;
        check("wb_rd0_take", ws.dram_take_over, 1'b1);
        check("wb_rd0_raddr", ws.data_raddr, 10'h048);
        for (int k = 1; k < 4; k++) begin
            tick(); rs.rdata[1] = line[k-1]; #1;
            check("wb_rd_take", ws.dram_take_over, 1'b1);
            check("wb_rd_raddr", ws.data_raddr, 10'h048 + k);
        end
        tick(); rs.rdata[1] = line[3]; #1;
        check("wb_rd4_take", ws.dram_take_over, 1'b0);
        check("wb_rd4_aw", aw_valid, 1'b0);
        tick(); rs.rdata[1] = 32'hBAD0_0002; #1;
        check("wb_aw_valid", aw_valid, 1'b1);
        check("wb_aw_addr", aw_addr, 32'h0ABC_D120);
        check("wb_aw_len", aw_len, 8'd3);
        check("wb_aw_size", aw_size, 2'd2);
        check("wb_aw_no_ar", ar_valid, 1'b0);
        aw_ready = 1;
        tick(); aw_ready = 0; w_ready = 0; #1;
        check("wb_w0_valid", w_valid, 1'b1);
        check("wb_w0_data", w_data, line[0]);
        check("wb_w0_strb", w_strb, 4'hF);
        tick(); w_ready = 1; #1;
        check("wb_w0_hold", w_data, line[0]);
        check("wb_w0_last", w_last, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick(); #1;
            check("wb_w_data", w_data, line[k]);
            check("wb_w_last", w_last, (k == 3) ? 1'b1 : 1'b0);
        end
        tick(); w_ready = 0; #1;
        check("wb_b_w_valid", w_valid, 1'b0);
        check("wb_b_no_ar", ar_valid, 1'b0);
        tick(); b_valid = 1; #1;
        check("wb_b_no_ar2", ar_valid, 1'b0);
        tick(); b_valid = 0; #1;
        check("wb_ar_valid", ar_valid, 1'b1);
        check("wb_ar_addr", ar_addr, 32'h0005_5120);
        ar_ready = 1;
        tick(); ar_ready = 0; r_valid = 1; r_data = 32'h0102_0304; #1;
        check("mw_b0_we", wr.data_we, 8'hF0);
        check("mw_b0_waddr", wr.data_waddr, 10'h048);
        check("mw_b0_wdata", wr.data_wdata, 32'h0102_0304);
        tick(); r_data = 32'h0506_0708; #1;
        check("mw_b1_merge", wr.data_wdata, 32'h05BB_07DD);
        check("mw_b1_waddr", wr.data_waddr, 10'h049);
        tick(); r_data = 32'h090A_0B0C; #1;
        check("mw_b2_wdata", wr.data_wdata, 32'h090A_0B0C);
        tick(); r_data = 32'h0D0E_0F10; r_last = 1; #1;
        check("mw_b3_waddr", wr.data_waddr, 10'h04B);
        tick(); r_valid = 0; r_last = 0; #1;
        check("mw_tag_we", wr.tag_we, 2'b10);
        check("mw_tag_wdata", wr.tag_wdata, 22'h30_0055);
        check("mw_uop_ready", ws.uop_ready, 1'b1);
        check("mw_no_read_ready", ws.read_ready, 1'b0);
        tick(); #1;
        check("mw_uop_pulse", ws.uop_ready, 1'b0);

        // ---- counter wrapped to 0: clean refill picks way0; reset mid-burst
        tick();
        rs.tag_rdata[0] = '{valid: 1'b1, dirty: 1'b0, tag: 20'h11111};
        rs.tag_rdata[1] = '{valid: 1'b1, dirty: 1'b0, tag: 20'h22222};
        rs.cache_refill_valid = 1; rs.addr = 32'h0000_3000; #1;
        tick(); rs.cache_refill_valid = 0; #1;
        check("rr_ar_addr", ar_addr, 32'h0000_3000);
        ar_ready = 1;
        tick(); ar_ready = 0; r_valid = 1; r_data = 32'h5555_0000; #1;
        check("rr_wrap_way0", wr.data_we, 8'h0F);
        tick(); r_data = 32'h5555_0001; #1;
        tick(); r_data = 32'h5555_0002; rst_n = 0; #1;
        check("rstm_b2_we", wr.data_we, 8'h0F);
        tick(); r_valid = 0; #1;
        check("rstm_data_we", wr.data_we, 8'h00);
        check("rstm_tag_we", wr.tag_we, 2'b00);
        check("rstm_ar_valid", ar_valid, 1'b0);
        check("rstm_take", ws.dram_take_over, 1'b0);
        check("rstm_read_ready", ws.read_ready, 1'b0);
        check("rstm_uwr_ready", ws.uncached_write_ready, 1'b1);
        tick(); rst_n = 1; rs = '0;

        // ---- uncached write followed by an uncached read
        tick();
        rs.uncached_write_valid = 1; rs.addr = 32'h8000_0010; rs.rwsize = 2'd2;
        rs.wstrobe = 4'hF; rs.wdata = 32'h1234_5678; #1;
        check("ucw_ready", ws.uncached_write_ready, 1'b1);
        tick(); rs.uncached_write_valid = 0; rs.uncached_read = 1;
        rs.addr = 32'h8000_0022; rs.rwsize = 2'd1; #1;
        check("ucw_aw_uwr", ws.uncached_write_ready, 1'b0);
        check("ucw_aw_valid", aw_valid, 1'b1);
        check("ucw_aw_addr", aw_addr, 32'h8000_0010);
        check("ucw_aw_len", aw_len, 8'd0);
        check("ucw_aw_size", aw_size, 2'd2);
        check("ucw_aw_no_ar", ar_valid, 1'b0);
        aw_ready = 1;
        tick(); aw_ready = 0; w_ready = 1; #1;
        check("ucw_w_valid", w_valid, 1'b1);
        check("ucw_w_data", w_data, 32'h1234_5678);
        check("ucw_w_strb", w_strb, 4'hF);
        check("ucw_w_last", w_last, 1'b1);
        tick(); w_ready = 0; #1;
        check("ucw_b_no_ar", ar_valid, 1'b0);
        check("ucw_b_uwr", ws.uncached_write_ready, 1'b0);
        tick(); b_valid = 1; #1;
        check("ucw_b_no_ar2", ar_valid, 1'b0);
        tick(); b_valid = 0; #1;
        check("ucr_idle_no_ar", ar_valid, 1'b0);
        check("ucr_idle_uwr", ws.uncached_write_ready, 1'b0);
        tick(); rs.uncached_read = 0; #1;
        check("ucr_ar_valid", ar_valid, 1'b1);
        check("ucr_ar_addr", ar_addr, 32'h8000_0022);
        check("ucr_ar_len", ar_len, 8'd0);
        check("ucr_ar_size", ar_size, 2'd1);
        ar_ready = 1;
        tick(); ar_ready = 0; #1;
        check("ucr_wait_rr", ws.read_ready, 1'b0);
        tick(); r_valid = 1; r_data = 32'hCAFE_F00D; r_last = 1; #1;
        check("ucr_read_ready", ws.read_ready, 1'b1);
        check("ucr_rdata", ws.rdata, 32'hCAFE_F00D);
        tick(); r_valid = 0; r_last = 0; #1;
        check("ucr_rr_pulse", ws.read_ready, 1'b0);
        check("ucr_idle_uwr2", ws.uncached_write_ready, 1'b1);

        // ---- invalidate way1, then invwb on a clean way0
        tick(); rs.cache_op_inv = 1; rs.addr = 32'h0000_0341; #1;
        tick(); rs.cache_op_inv = 0; #1;
        check("inv_tag_we", wr.tag_we, 2'b10);
        check("inv_tag_wdata", wr.tag_wdata, 22'h0);
        check("inv_tag_waddr", wr.tag_waddr, 8'h34);
        check("inv_uop_ready", ws.uop_ready, 1'b1);
        check("inv_no_ar", ar_valid, 1'b0);
        check("inv_no_aw", aw_valid, 1'b0);
        tick(); #1;
        check("inv_uop_pulse", ws.uop_ready, 1'b0);
        check("inv_tag_we_off", wr.tag_we, 2'b00);
        tick();
        rs.tag_rdata[0] = '{valid: 1'b1, dirty: 1'b0, tag: 20'h77777};
        rs.cache_op_invwb = 1; rs.addr = 32'h0000_0340; #1;
        tick(); rs.cache_op_invwb = 0; #1;
        check("invwb_clean_uop", ws.uop_ready, 1'b1);
        check("invwb_clean_tag_we", wr.tag_we, 2'b01);
        check("invwb_clean_take", ws.dram_take_over, 1'b0);
        tick(); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
